// File: rtl/bcd_display_encoder.sv
// Binary to BCD (double dabble) with 7-segment output per digit.
// Optional leading-zero blanking and sticky overflow beyond DIGITS.
module bcd_display_encoder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int BLANK  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      entrada,
  output logic [WIDTH-1:0]      saida,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   displays
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]    bin, bin_sh;
  logic [BW-1:0]       bcd, adj, bcd_sh;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                ovf_acc;
  logic [7*DIGITS-1:0] seg_n;
  logic                lead;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ready) state_n = SHIFT;
      SHIFT:   if (last) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A carry out of the top nibble means the value wraps modulo 10^DIGITS.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i+:4] > 4'd4) adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
    end
    carry  = adj[BW-1];
    bcd_sh = {adj[BW-2:0], bin[WIDTH-1]};
    bin_sh = {bin[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    seg_n = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i+:4] != 4'd0) lead = 1'b0;
      if (BLANK != 0 && lead && i != 0) seg_n[7*i+:7] = 7'h00;
      else                              seg_n[7*i+:7] = seg7(bcd[4*i+:4]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      saida    <= '0;
      displays <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ready) begin
            bin     <= entrada;
            saida   <= entrada;
            bcd     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        SHIFT: begin
          bin     <= bin_sh;
          bcd     <= bcd_sh;
          cnt     <= cnt + 1'b1;
          ovf_acc <= ovf_acc | carry;
        end
        LOAD: begin
          displays <= seg_n;
          ovf      <= ovf_acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_encoder.sv
// Bench for bcd_display_encoder: three parameter sets against an
// arithmetic decimal/segment reference model.
module tb_bcd_display_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [7:0] ent;
  int         sel;

  logic [7:0]  saida_a, saida_b;
  logic [3:0]  saida_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [20:0] disp_a, disp_b;
  logic [6:0]  disp_c;

  logic [7:0]  c_saida;
  logic        c_busy, c_done, c_ovf;
  logic [34:0] c_disp;

  int passed = 0;
  int total  = 0;

  logic [34:0] exp_disp [3];
  bit          exp_ovf  [3];

  logic [6:0] segtab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  always #5 clk = ~clk;

  bcd_display_encoder #(.WIDTH(8), .DIGITS(3), .BLANK(1)) u_a (
    .clock(clk), .reset(rst), .ready(rdy && sel == 0), .entrada(ent),
    .saida(saida_a), .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .displays(disp_a)
  );

  bcd_display_encoder #(.WIDTH(8), .DIGITS(3), .BLANK(0)) u_b (
    .clock(clk), .reset(rst), .ready(rdy && sel == 1), .entrada(ent),
    .saida(saida_b), .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .displays(disp_b)
  );

  bcd_display_encoder #(.WIDTH(4), .DIGITS(1), .BLANK(1)) u_c (
    .clock(clk), .reset(rst), .ready(rdy && sel == 2), .entrada(ent[3:0]),
    .saida(saida_c), .busy(busy_c), .done(done_c), .ovf(ovf_c),
    .displays(disp_c)
  );

  always_comb begin
    c_saida = saida_a;
    c_busy  = busy_a;
    c_done  = done_a;
    c_ovf   = ovf_a;
    c_disp  = 35'(disp_a);
    case (sel)
      1: begin
        c_saida = saida_b; c_busy = busy_b; c_done = done_b;
        c_ovf = ovf_b; c_disp = 35'(disp_b);
      end
      2: begin
        c_saida = {4'd0, saida_c}; c_busy = busy_c; c_done = done_c;
        c_ovf = ovf_c; c_disp = 35'(disp_c);
      end
      default: ;
    endcase
  end

  function automatic int w_of(input int s);
    return (s == 2) ? 4 : 8;
  endfunction

  function automatic int d_of(input int s);
    return (s == 2) ? 1 : 3;
  endfunction

  function automatic int b_of(input int s);
    return (s == 1) ? 0 : 1;
  endfunction

  function automatic void model(input int v, input int d, input int b,
                                output logic [34:0] disp, output bit ov);
    int p, m, msd;
    int dig [5];
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    ov  = (v >= p);
    m   = v % p;
    msd = 0;
    for (int i = 0; i < 5; i++) begin
      dig[i] = m % 10;
      m = m / 10;
      if (dig[i] != 0) msd = i;
    end
    disp = '0;
    for (int i = 0; i < d; i++)
      if (b == 0 || i <= msd) disp[7*i+:7] = segtab[dig[i]];
  endfunction

  task automatic clear_exp();
    for (int s = 0; s < 3; s++) begin
      exp_disp[s] = '0;
      exp_ovf[s]  = 1'b0;
    end
  endtask

  // Starts and ends on a falling edge; ready is sampled at the next edge.
  task automatic convert(input int v, input bit b2b);
    logic [34:0] ed;
    bit          eo;
    int          k, bc, w;
    w = w_of(sel);
    model(v, d_of(sel), b_of(sel), ed, eo);
    ent = 8'(v);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    total++;
    if (c_saida !== 8'(v))
      $display("FAIL saida s%0d: got %0d want %0d", sel, c_saida, v);
    else passed++;
    total++;
    if (c_disp !== exp_disp[sel] || c_ovf !== exp_ovf[sel])
      $display("FAIL hold s%0d: got %h/%b want %h/%b", sel, c_disp, c_ovf,
               exp_disp[sel], exp_ovf[sel]);
    else passed++;
    k = 0;
    bc = 0;
    while (k < 40 && c_done !== 1'b1) begin
      if (c_busy === 1'b1) bc++;
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== w + 1)
      $display("FAIL latency s%0d v=%0d: got %0d want %0d", sel, v, k, w + 1);
    else passed++;
    total++;
    if (bc !== w + 1 || c_busy !== 1'b0)
      $display("FAIL busy s%0d: got %0d cycles want %0d", sel, bc, w + 1);
    else passed++;
    total++;
    if (c_disp !== ed)
      $display("FAIL displays s%0d v=%0d: got %h want %h", sel, v, c_disp, ed);
    else passed++;
    total++;
    if (c_ovf !== eo)
      $display("FAIL ovf s%0d v=%0d: got %b want %b", sel, v, c_ovf, eo);
    else passed++;
    exp_disp[sel] = ed;
    exp_ovf[sel]  = eo;
    if (!b2b) begin
      @(negedge clk);
      total++;
      if (c_done !== 1'b0)
        $display("FAIL done_width s%0d: got %b want 0", sel, c_done);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b0;
    ent = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_exp();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if ({c_busy, c_done, c_ovf} !== 3'b000 || c_disp !== '0 || c_saida !== '0)
        $display("FAIL reset s%0d: got b%b d%b o%b %h %h want zeros",
                 s, c_busy, c_done, c_ovf, c_disp, c_saida);
      else passed++;
    end
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_known();
    sel = 0;
    convert(0, 0);
    total++;
    if (c_disp !== {14'd0, 7'h00, 7'h00, 7'h7E} || c_saida !== 8'h00)
      $display("FAIL known0: got %h want 0000007e", c_disp);
    else passed++;
    convert(255, 0);
    total++;
    if (c_disp !== {14'd0, 7'h6D, 7'h5B, 7'h5B} || c_ovf !== 1'b0)
      $display("FAIL known255: got %h want 6d5b5b", c_disp);
    else passed++;
    convert(105, 0);
    total++;
    if (c_disp !== {14'd0, 7'h30, 7'h7E, 7'h5B})
      $display("FAIL known105: got %h want 307e5b", c_disp);
    else passed++;
    sel = 1;
    convert(7, 0);
    total++;
    if (c_disp !== {14'd0, 7'h7E, 7'h7E, 7'h70})
      $display("FAIL noblank7: got %h want 7e7e70", c_disp);
    else passed++;
    sel = 2;
    convert(12, 0);
    total++;
    if (c_disp !== 35'h6D || c_ovf !== 1'b1)
      $display("FAIL ovf12: got %h/%b want 6d/1", c_disp, c_ovf);
    else passed++;
    convert(9, 0);
    total++;
    if (c_disp !== 35'h7B || c_ovf !== 1'b0)
      $display("FAIL w4_9: got %h/%b want 7b/0", c_disp, c_ovf);
    else passed++;
    sel = 0;
  endtask

  task automatic test_ignore_ready();
    logic [34:0] ed, got;
    bit          eo;
    int          dcount, dk;
    sel = 0;
    model(42, 3, 1, ed, eo);
    ent = 8'd42;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    ent = 8'd99;
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    dcount = 0;
    dk = -1;
    got = '0;
    for (int j = 6; j < 24; j++) begin
      @(negedge clk);
      if (c_done === 1'b1) begin
        dcount++;
        dk = j;
        got = c_disp;
      end
    end
    total++;
    if (dcount !== 1 || dk !== 9)
      $display("FAIL ignore_done: got %0d pulses at %0d want 1 at 9", dcount, dk);
    else passed++;
    total++;
    if (got !== ed || c_saida !== 8'd42)
      $display("FAIL ignore_val: got %h/%0d want %h/42", got, c_saida, ed);
    else passed++;
    exp_disp[0] = ed;
    exp_ovf[0]  = eo;
    convert(99, 0);
    total++;
    if (c_disp !== {14'd0, 7'h00, 7'h7B, 7'h7B})
      $display("FAIL known99: got %h want 007b7b", c_disp);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int dcount;
    sel = 0;
    ent = 8'd200;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_exp();
    total++;
    if ({c_busy, c_done, c_ovf} !== 3'b000 || c_disp !== '0 || c_saida !== '0)
      $display("FAIL abort_clear: got b%b d%b o%b %h %h want zeros",
               c_busy, c_done, c_ovf, c_disp, c_saida);
    else passed++;
    dcount = 0;
    for (int j = 0; j < 15; j++) begin
      if (c_done === 1'b1) dcount++;
      @(negedge clk);
    end
    total++;
    if (dcount !== 0)
      $display("FAIL abort_done: got %0d pulses want 0", dcount);
    else passed++;
    convert(200, 0);
    total++;
    if (c_disp !== {14'd0, 7'h6D, 7'h7E, 7'h7E})
      $display("FAIL known200: got %h want 6d7e7e", c_disp);
    else passed++;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    convert(17, 1);
    convert(250, 1);
    convert(3, 0);
    sel = 2;
    convert(15, 1);
    convert(4, 0);
    sel = 0;
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 25; n++)
        convert(int'($urandom_range((1 << w_of(s)) - 1, 0)), n[0]);
      @(negedge clk);
    end
    sel = 0;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    ent = '0;
    sel = 0;
    clear_exp();
    test_reset();
    test_known();
    test_ignore_ready();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
